// File: rtl/alu_pkg.sv
// alu_pkg: shared types and helpers for the alu_multicycle block.
// Holds the 4-bit op-code enum, the control FSM state enum and the
// mul/div classification helper used by the top level.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_XOR   = 4'b0011,
    OP_SLL   = 4'b0100,
    OP_SRL   = 4'b0101,
    OP_SUB   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_SLTU  = 4'b1000,
    OP_MULT  = 4'b1001,
    OP_MULTU = 4'b1010,
    OP_DIV   = 4'b1011,
    OP_NOR   = 4'b1100,
    OP_SRA   = 4'b1101,
    OP_DIVU  = 4'b1110
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  // True for the ops that run on the iterative engine.
  function automatic logic is_muldiv(alu_op_e op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// alu_multicycle_if: request/response bundle of the multi-cycle ALU.
// master = pipeline side (issues ops, takes results), slave = ALU.
interface alu_multicycle_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             overflow;
  logic             div_by_zero;
  logic             illegal;

  modport master (
    output in_valid, op, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, hi, zero, overflow, div_by_zero, illegal
  );

  modport slave (
    input  in_valid, op, src_a, src_b, out_ready,
    output in_ready, out_valid, result, hi, zero, overflow, div_by_zero, illegal
  );

endinterface

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative multiply/divide engine, one bit per cycle on
// operand magnitudes, sign fixed up on the way out.
// Divide datapath present only when ALU_MULTICYCLE_DIV_EN is defined.
// done_o pulses on the cycle whose edge performs the final iteration;
// lo_o/hi_o then carry the finished result so the caller can register it
// on that same edge.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             div_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic                 busy_q, busy_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  // Multiply: {partial upper, multiplier}. Divide: {remainder, quotient}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 neg_q, neg_d;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [2*WIDTH-1:0]   step_next;
  logic [2*WIDTH-1:0]   prod;

  assign mag_a = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign mag_b = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

  // Shift-add: add multiplicand into the upper half when the LSB is set.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef ALU_MULTICYCLE_DIV_EN
  logic                 div_q, div_d;
  logic                 rem_neg_q, rem_neg_d;
  logic [WIDTH:0]       div_shift, div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   div_next;
  logic [WIDTH-1:0]     quo_mag, rem_mag;

  // Restoring step: shift in the next dividend bit, subtract if it fits.
  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_ge    = ~div_diff[WIDTH];
  assign div_next  = {div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0],
                      acc_q[WIDTH-2:0], div_ge};
  assign step_next = div_q ? div_next : mul_next;
  assign quo_mag   = acc_d[WIDTH-1:0];
  assign rem_mag   = acc_d[2*WIDTH-1:WIDTH];
`else
  logic unused_div;
  assign unused_div = div_i;
  assign step_next  = mul_next;
`endif

  assign prod   = neg_q ? -acc_d : acc_d;
  assign done_o = busy_q && (cnt_q == LAST);

  // Next-state of the engine: load on start, iterate while busy.
  // NOTE: every variable written here gets a default first, otherwise an
  // unassigned path would infer a latch.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    b_d    = b_q;
    neg_d  = neg_q;
`ifdef ALU_MULTICYCLE_DIV_EN
    div_d     = div_q;
    rem_neg_d = rem_neg_q;
`endif
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      acc_d  = {{WIDTH{1'b0}}, mag_a};
      b_d    = mag_b;
      neg_d  = signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
`ifdef ALU_MULTICYCLE_DIV_EN
      div_d     = div_i;
      rem_neg_d = signed_i && a_i[WIDTH-1];
`endif
    end else if (busy_q) begin
      cnt_d = cnt_q + 1'b1;
      acc_d = step_next;
      if (cnt_q == LAST) busy_d = 1'b0;
    end
  end

  // Result presentation: full product, or signed quotient/remainder.
  always_comb begin
    lo_o = prod[WIDTH-1:0];
    hi_o = prod[2*WIDTH-1:WIDTH];
`ifdef ALU_MULTICYCLE_DIV_EN
    if (div_q) begin
      lo_o = neg_q     ? -quo_mag : quo_mag;
      hi_o = rem_neg_q ? -rem_mag : rem_mag;
    end
`endif
  end

  // Control registers: synchronous active-low reset aborts any iteration.
  // NOTE: sequential state uses non-blocking <= so all flops update from
  // the same pre-edge values; combinational blocks above use blocking =.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Datapath registers: only meaningful while busy_q, loaded on start.
  // NOTE: no reset here on purpose; busy_q gates every use, so resetting
  // the wide datapath would only cost reset routing.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    b_q   <= b_d;
    neg_q <= neg_d;
`ifdef ALU_MULTICYCLE_DIV_EN
    div_q     <= div_d;
    rem_neg_q <= rem_neg_d;
`endif
  end

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked EX-stage ALU. Single-cycle ops finish with
// one registered cycle; MULT/MULTU/DIV/DIVU iterate in alu_muldiv.
// Optional feature: define ALU_MULTICYCLE_DIV_EN to build the divider;
// without it DIV/DIVU are reported as illegal ops.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_multicycle_if.slave    bus
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, dbz_q, dbz_d, ill_q, ill_d;

  alu_op_e          op_e;
  logic [WIDTH-1:0] a, b, sum, diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sc_result, sc_hi;
  logic             sc_ovf, sc_dbz, sc_ill;
  logic             accept, go_busy, md_start, md_done;
  logic [WIDTH-1:0] md_lo, md_hi;

  assign op_e   = alu_op_e'(bus.op);
  assign a      = bus.src_a;
  assign b      = bus.src_b;
  assign sum    = a + b;
  assign diff   = a - b;
  assign shamt  = b[SHW-1:0];
  assign accept = bus.in_valid && bus.in_ready;

  // Single-cycle unit; also resolves illegal ops and divide by zero.
  always_comb begin
    sc_result = '0;
    sc_hi     = '0;
    sc_ovf    = 1'b0;
    sc_dbz    = 1'b0;
    sc_ill    = 1'b0;
    case (op_e)
      OP_AND:  sc_result = a & b;
      OP_OR:   sc_result = a | b;
      OP_XOR:  sc_result = a ^ b;
      OP_NOR:  sc_result = ~(a | b);
      OP_ADD: begin
        sc_result = sum;
        sc_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result = diff;
        sc_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLL:  sc_result = a << shamt;
      OP_SRL:  sc_result = a >> shamt;
      OP_SRA:  sc_result = $signed(a) >>> shamt;
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, a < b};
      OP_MULT, OP_MULTU: begin
        sc_result = '0;
      end
      OP_DIV, OP_DIVU: begin
`ifdef ALU_MULTICYCLE_DIV_EN
        if (b == '0) begin
          sc_result = '1;
          sc_hi     = a;
          sc_dbz    = 1'b1;
        end
`else
        sc_ill = 1'b1;
`endif
      end
      default: sc_ill = 1'b1;
    endcase
  end

  assign go_busy = is_muldiv(op_e) && !sc_ill && !sc_dbz;

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (md_start),
    .div_i    (op_e == OP_DIV || op_e == OP_DIVU),
    .signed_i (op_e == OP_MULT || op_e == OP_DIV),
    .a_i      (a),
    .b_i      (b),
    .done_o   (md_done),
    .lo_o     (md_lo),
    .hi_o     (md_hi)
  );

  // FSM next state and output-register loads.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    ill_d    = ill_q;
    md_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (go_busy) begin
            md_start = 1'b1;
            state_d  = BUSY;
          end else begin
            state_d  = DONE;
            result_d = sc_result;
            hi_d     = sc_hi;
            zero_d   = (sc_result == '0);
            ovf_d    = sc_ovf;
            dbz_d    = sc_dbz;
            ill_d    = sc_ill;
          end
        end
      end
      BUSY: begin
        if (md_done) begin
          state_d  = DONE;
          result_d = md_lo;
          hi_d     = md_hi;
          zero_d   = (md_lo == '0);
          ovf_d    = 1'b0;
          dbz_d    = 1'b0;
          ill_d    = 1'b0;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
      ill_q    <= ill_d;
    end
  end

  // in_ready is forced high while reset is asserted.
  assign bus.in_ready    = !rst_n || (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.result      = result_q;
  assign bus.hi          = hi_q;
  assign bus.zero        = zero_q;
  assign bus.overflow    = ovf_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.illegal     = ill_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: scoreboard bench for alu_multicycle (WIDTH=32).
// Stimulus pushes reference results into a queue; an independent monitor
// pops and compares whenever out_valid rises, then checks hold-stability.
module tb_alu_multicycle;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_multicycle_if #(.WIDTH(W)) bus ();

  alu_multicycle #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] res;
    logic [31:0] hi;
    logic        zero;
    logic        ovf;
    logic        dbz;
    logic        ill;
    int          lat;
    int          acc_edge;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   showing = 1'b0;
  bit   bp_flag = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   edge_cnt = 0;
  int   rst_edges = 0;

  logic [3:0]  d_op [9] = '{4'b0010, 4'b0110, 4'b1101, 4'b1111, 4'b1001,
                            4'b1010, 4'b1011, 4'b1011, 4'b1110};
  logic [31:0] d_a  [9] = '{32'h7FFFFFFF, 32'd5, 32'h80000000, 32'h12345678,
                            32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9,
                            32'h80000000, 32'd9};
  logic [31:0] d_b  [9] = '{32'd1, 32'd5, 32'd4, 32'h9ABCDEF0, 32'd7,
                            32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'd0};

  always @(posedge clk) begin
    edge_cnt  <= edge_cnt + 1;
    rst_edges <= rst_n ? 0 : rst_edges + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model from the arithmetic definitions, using 64-bit math.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb, wide, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.op = op; e.res = '0; e.hi = '0;
    e.ovf = 1'b0; e.dbz = 1'b0; e.ill = 1'b0; e.lat = 1; e.acc_edge = 0;
    case (op)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0011: e.res = a ^ b;
      4'b1100: e.res = ~(a | b);
      4'b0010: begin
        wide = sa + sb; e.res = a + b;
        e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'b0110: begin
        wide = sa - sb; e.res = a - b;
        e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'b0100: e.res = a << b[4:0];
      4'b0101: e.res = a >> b[4:0];
      4'b1101: e.res = $signed(a) >>> b[4:0];
      4'b0111: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'b1000: e.res = (a < b) ? 32'd1 : 32'd0;
      4'b1001: begin
        p = sa * sb; e.res = p[31:0]; e.hi = p[63:32]; e.lat = 33;
      end
      4'b1010: begin
        p = {32'b0, a} * {32'b0, b}; e.res = p[31:0]; e.hi = p[63:32]; e.lat = 33;
      end
`ifdef ALU_MULTICYCLE_DIV_EN
      4'b1011: begin
        if (b == 0) begin
          e.res = '1; e.hi = a; e.dbz = 1'b1;
        end else begin
          // 64-bit division truncates toward zero; MIN / -1 wraps back to MIN.
          q = sa / sb; r = sa % sb;
          p = q; e.res = p[31:0];
          p = r; e.hi = p[31:0];
          e.lat = 33;
        end
      end
      4'b1110: begin
        if (b == 0) begin
          e.res = '1; e.hi = a; e.dbz = 1'b1;
        end else begin
          e.res = a / b; e.hi = a % b; e.lat = 33;
        end
      end
`endif
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.res == 0);
    return e;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   budget;
    bus.op = op; bus.src_a = a; bus.src_b = b; bus.in_valid = 1'b1;
    budget = 0;
    while (!bus.in_ready && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.in_ready) begin
      check("in_ready wait bound", bus.in_ready, 1);
      bus.in_valid = 1'b0;
      return;
    end
    e = model(op, a, b);
    e.acc_edge = edge_cnt + 1;
    exp_q.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op = $urandom; bus.src_a = $urandom; bus.src_b = $urandom;
  endtask

  // Consumer: out_ready changes just after each rising edge.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = bp_flag ? 1'b0 : ($urandom_range(3) != 0);
    end
  end

  // Monitor: reset values, scoreboard pop on each new result, hold checks.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        showing = 1'b0;
        check("in_ready during reset", bus.in_ready, 1);
        if (rst_edges > 0) begin
          check("reset flags", {bus.out_valid, bus.zero, bus.overflow, bus.div_by_zero, bus.illegal}, 0);
          check("reset result", bus.result, 0);
          check("reset hi", bus.hi, 0);
        end
      end else if (bus.out_valid) begin
        if (!showing) begin
          if (exp_q.size() == 0) begin
            check("out_valid with empty scoreboard", bus.out_valid, 0);
          end else begin
            cur = exp_q.pop_front();
            showing = 1'b1;
            check($sformatf("latency op=%b", cur.op), edge_cnt + 1 - cur.acc_edge, cur.lat);
          end
        end
        if (showing) begin
          check($sformatf("result op=%b", cur.op), bus.result, cur.res);
          check($sformatf("hi op=%b", cur.op), bus.hi, cur.hi);
          check($sformatf("flags zero/ovf/dbz/ill op=%b", cur.op),
                {bus.zero, bus.overflow, bus.div_by_zero, bus.illegal},
                {cur.zero, cur.ovf, cur.dbz, cur.ill});
          check("in_ready while out_valid", bus.in_ready, 0);
          if (bus.out_ready) showing = 1'b0;
        end
      end else if (showing) begin
        check("out_valid held until out_ready", bus.out_valid, 1);
        showing = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int budget;
    int seen;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.op = '0; bus.src_a = '0; bus.src_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) issue(d_op[i], d_a[i], d_b[i]);

    // Backpressure: result held for 10 cycles, second op waits behind it.
    @(negedge clk);
    bp_flag = 1'b1;
    fork
      begin
        issue(4'b0010, 32'h00001234, 32'h00004321);
        issue(4'b0011, 32'hA5A5A5A5, 32'h0F0F0F0F);
      end
      begin
        budget = 0;
        while (!bus.out_valid && budget < 50) begin
          @(negedge clk);
          budget++;
        end
        check("backpressure out_valid seen", bus.out_valid, 1);
        repeat (10) @(negedge clk);
        bp_flag = 1'b0;
      end
    join

    for (int i = 0; i < 200; i++) begin
      issue(4'($urandom_range(15)), rand_operand(), rand_operand());
      if ($urandom_range(3) == 0) @(negedge clk);
    end

    budget = 0;
    while ((exp_q.size() != 0 || showing) && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    check("scoreboard drained", exp_q.size(), 0);

    // Abort: reset at cycle 10 of a MULT; nothing may come out for it.
    issue(4'b1001, 32'hFFFFFFFD, 32'd7);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("aborted op produced no out_valid", seen, 0);
    check("in_ready after abort", bus.in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
